// File: rtl/udp_tx_framer.sv
// udp_tx_framer: store-and-forward UDP TX framer.
// Buffers one payload frame from the register-control TX stream and measures
// its length. It then presents a UDP header followed by the buffered payload.
// Frames longer than DEPTH are discarded whole and flagged with a drop pulse.
module udp_tx_framer #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] DEST_IP   = {8'd192, 8'd168, 8'd1, 8'd128},
    parameter logic [15:0] DEST_PORT = 16'd1234,
    parameter logic [15:0] SRC_PORT  = 16'd1234
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_s_axis_tdata,
    input  logic        i_s_axis_tvalid,
    input  logic        i_s_axis_tlast,
    output logic        o_s_axis_tready,
    output logic        o_hdr_valid,
    input  logic        i_hdr_ready,
    output logic [31:0] o_hdr_ip_dest,
    output logic [15:0] o_hdr_dest_port,
    output logic [15:0] o_hdr_src_port,
    output logic [15:0] o_hdr_length,
    output logic [7:0]  o_m_axis_tdata,
    output logic        o_m_axis_tvalid,
    output logic        o_m_axis_tlast,
    input  logic        i_m_axis_tready,
    output logic        o_drop,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_DROP,
        S_HDR,
        S_SEND
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [7:0]    mem [DEPTH];
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_ptr_q;
    logic [15:0]   len_q;
    logic [15:0]   hdr_len_q;
    logic          drop_q;

    logic          full;
    logic          in_fire;
    logic          out_fire;
    logic          last_rd;

    // Buffer is full once DEPTH bytes are held; a further byte means overflow.
    assign full     = (wr_cnt_q == CW'(DEPTH));
    assign in_fire  = i_s_axis_tvalid && o_s_axis_tready;
    assign out_fire = o_m_axis_tvalid && i_m_axis_tready;
    assign last_rd  = (16'(rd_ptr_q) == (len_q - 16'd1));

    // Input is only accepted while collecting or discarding, never during reset.
    assign o_s_axis_tready = i_rst_n && ((state_q == S_FILL) || (state_q == S_DROP));

    assign o_hdr_valid     = (state_q == S_HDR);
    assign o_hdr_ip_dest   = DEST_IP;
    assign o_hdr_dest_port = DEST_PORT;
    assign o_hdr_src_port  = SRC_PORT;
    assign o_hdr_length    = hdr_len_q;

    // Data output is zeroed outside S_SEND so stale buffer bytes never leak.
    assign o_m_axis_tvalid = (state_q == S_SEND);
    assign o_m_axis_tdata  = (state_q == S_SEND) ? mem[rd_ptr_q[AW-1:0]] : 8'h00;
    assign o_m_axis_tlast  = (state_q == S_SEND) && last_rd;

    assign o_drop = drop_q;
    assign o_busy = (state_q == S_HDR) || (state_q == S_SEND);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (in_fire) begin
                    if (!full && i_s_axis_tlast) begin
                        state_d = S_HDR;
                    end else if (full && !i_s_axis_tlast) begin
                        state_d = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (in_fire && i_s_axis_tlast) begin
                    state_d = S_FILL;
                end
            end
            S_HDR: begin
                if (i_hdr_ready) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_fire && last_rd) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Counters, latched length and the drop pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_cnt_q  <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            hdr_len_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (in_fire) begin
                        if (!full) begin
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                            if (i_s_axis_tlast) begin
                                len_q     <= 16'(wr_cnt_q) + 16'd1;
                                hdr_len_q <= 16'(wr_cnt_q) + 16'd9;
                            end
                        end else if (i_s_axis_tlast) begin
                            // Oversize frame ended exactly on the overflow byte.
                            drop_q   <= 1'b1;
                            wr_cnt_q <= '0;
                        end
                    end
                end
                S_DROP: begin
                    if (in_fire && i_s_axis_tlast) begin
                        drop_q   <= 1'b1;
                        wr_cnt_q <= '0;
                    end
                end
                S_HDR: begin
                    if (i_hdr_ready) begin
                        rd_ptr_q <= '0;
                    end
                end
                S_SEND: begin
                    if (out_fire) begin
                        rd_ptr_q <= rd_ptr_q + CW'(1);
                        if (last_rd) begin
                            wr_cnt_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload buffer write; contents need no reset.
    always_ff @(posedge i_clk) begin
        if ((state_q == S_FILL) && in_fire && !full) begin
            mem[wr_cnt_q[AW-1:0]] <= i_s_axis_tdata;
        end
    end

endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
Store-and-forward framer that sits directly downstream of the register-control block's TX payload stream. It buffers one complete reply frame of bytes and measures its length. It then presents a UDP header (destination IP, ports, UDP length) followed by the buffered payload to the UDP/IP stack's TX header and payload interfaces. One frame is in flight at a time.

Parameters:
DEPTH, 64, payload buffer size in bytes; power of 2, 2..1024; also the maximum frame length.
DEST_IP, {8'd192,8'd168,8'd1,8'd128}, destination IP placed in every header.
DEST_PORT, 16'd1234, UDP destination port.
SRC_PORT, 16'd1234, UDP source port.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
i_s_axis_tdata  in  8  payload byte from register-control TX
i_s_axis_tvalid  in  1  input byte valid
i_s_axis_tlast  in  1  last byte of frame
o_s_axis_tready  out  1  input ready
o_hdr_valid  out  1  header valid
i_hdr_ready  in  1  header accepted by UDP stack
o_hdr_ip_dest  out  32  = DEST_IP
o_hdr_dest_port  out  16  = DEST_PORT
o_hdr_src_port  out  16  = SRC_PORT
o_hdr_length  out  16  UDP length = payload bytes + 8
o_m_axis_tdata  out  8  payload byte to UDP stack
o_m_axis_tvalid  out  1  payload valid
o_m_axis_tlast  out  1  last payload byte
i_m_axis_tready  in  1  UDP stack ready
o_drop  out  1  one-cycle pulse: oversize frame discarded
o_busy  out  1  high in S_HDR or S_SEND

Behaviour:
- Storage: DEPTH x 8 array with asynchronous read. wr_cnt and rd_ptr are clog2(DEPTH)+1 bits. Latched length len is 16 bits.
- States: S_FILL, S_DROP, S_HDR, S_SEND.
- o_s_axis_tready = 1 in S_FILL and S_DROP, otherwise 0. It is forced to 0 while i_rst_n = 0.
- S_FILL: each accepted byte (tvalid & tready) with wr_cnt < DEPTH is written to mem[wr_cnt], and wr_cnt increments.
  - Accepted byte with tlast and wr_cnt < DEPTH: len <= wr_cnt+1, go to S_HDR.
  - Accepted byte when wr_cnt == DEPTH (overflow) without tlast: go to S_DROP.
  - Accepted byte when wr_cnt == DEPTH with tlast: pulse o_drop next cycle, wr_cnt <= 0, stay in S_FILL.
- S_DROP: consume and discard bytes. On an accepted tlast, pulse o_drop for one cycle, wr_cnt <= 0, go to S_FILL.
- S_HDR: o_hdr_valid = 1, and all header fields stay stable until handshake. o_hdr_length = len + 8.
  - Header valid is asserted the cycle after the tlast byte is accepted (latency 1).
  - On i_hdr_ready go to S_SEND with rd_ptr = 0.
- S_SEND: o_m_axis_tvalid = 1, o_m_axis_tdata = mem[rd_ptr], o_m_axis_tlast = (rd_ptr == len-1).
  - First payload byte is valid the cycle after the header handshake.
  - tvalid is never dropped without a handshake, and data stays stable while i_m_axis_tready = 0.
  - On each handshake rd_ptr increments. On the handshake with tlast: wr_cnt <= 0, go to S_FILL.
- Frame of exactly DEPTH bytes is accepted. Frame of DEPTH+1 bytes or more is dropped whole; nothing partial is ever emitted.
- Minimum frame is 1 byte (len 1, o_hdr_length 9, tlast on the first payload byte).
- Backpressure: while in S_HDR/S_SEND the input is stalled. The upstream block must hold tvalid/tdata per AXI-stream rules.
- Reset (i_rst_n = 0 at a clock edge), at any time including mid-frame:
  - state <= S_FILL; wr_cnt, rd_ptr, len <= 0.
  - o_hdr_valid, o_m_axis_tvalid, o_m_axis_tlast, o_drop, o_busy all read 0, and o_m_axis_tdata reads 0.
  - The buffered frame is discarded. Memory contents need no reset.
- Header constant fields are driven from parameters at all times; only o_hdr_length is 0 after reset.

Test Plan:
- 4-byte frame 0xDE,0xAD,0xBE,0xEF (tlast on 0xEF), all readies high -> o_hdr_valid 1 cycle after tlast, o_hdr_length=12, ip 0xC0A80180, ports 1234/1234. Payload DE,AD,BE,EF with tlast only on EF. o_s_axis_tready=0 from tlast+1 until after the final handshake.
- Same frame with i_hdr_ready held low 5 cycles, then i_m_axis_tready toggling 1/0 -> header fields stable throughout, no payload before header handshake, each byte held until accepted, order preserved.
- 1-byte frame 0x41 with tlast -> o_hdr_length=9; single payload byte 0x41 with tlast=1.
- DEPTH=64: 64-byte frame (0x00..0x3F) -> accepted, o_hdr_length=72, tlast on 0x3F. Then 70-byte frame -> no header, one o_drop pulse after byte 70. Then 2-byte frame 0x11,0x22 -> o_hdr_length=10, payload 11,22.
- Reset asserted for 1 cycle after 3 bytes of a 5-byte frame -> outputs 0, nothing emitted. Remaining 2 bytes (incl. tlast) form a 2-byte frame with o_hdr_length=10.
- Back-to-back frames with tvalid continuously high -> second frame stalled (tready=0) during first frame's header/payload. Second frame then emitted correctly with its own length.
